// File: rtl/cheshire_idma_chan_sched.sv
// -----------------------------------------------------------------------------
// cheshire_idma_chan_sched
//
// Multi-channel job scheduler in front of a single in-order DMA backend.
// Channels are arbitrated round robin. An accepted job is held in a one-entry
// output register toward the backend. Its source channel is pushed into an
// in-order tracking FIFO. Each backend completion pops the FIFO head and
// retires one job of that channel.
//
// Optional feature, enabled by defining CHESHIRE_IDMA_SCHED_PRIO_EN:
//   adds prio_i. Requesting channels with prio_i high beat all others. The
//   high group is still served round robin, using the same pointer.
//
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   job_i, job_valid_i/ready_o  per-channel job payload and handshake
//   prio_i                      per-channel priority (only with the macro)
//   next_id_o                   ID that the next accepted job of each channel gets
//   done_id_o                   ID of the last retired job of each channel
//   be_job_o, be_chan_o         job and source channel sent to the backend
//   be_valid_o, be_ready_i      backend job handshake
//   be_rsp_valid_i/ready_o      in-order backend completion (ready tied high)
//   busy_o                      channel has at least one outstanding job
//   err_o                       sticky flag: completion seen while nothing outstanding
// -----------------------------------------------------------------------------
module cheshire_idma_chan_sched #(
   parameter  int unsigned NumChan  = 2,
   parameter  int unsigned IdWidth  = 32,
   parameter  int unsigned JobWidth = 128,
   parameter  int unsigned Depth    = 4,
   localparam int unsigned ChanW    = (NumChan > 1) ? $clog2(NumChan) : 1,
   localparam int unsigned PtrW     = $clog2(Depth),
   localparam int unsigned CntW     = PtrW + 1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NumChan-1:0][JobWidth-1:0]  job_i,
   input  logic [NumChan-1:0]                job_valid_i,
   output logic [NumChan-1:0]                job_ready_o,
`ifdef CHESHIRE_IDMA_SCHED_PRIO_EN
   input  logic [NumChan-1:0]                prio_i,
`endif
   output logic [NumChan-1:0][IdWidth-1:0]   next_id_o,
   output logic [NumChan-1:0][IdWidth-1:0]   done_id_o,
   output logic [JobWidth-1:0]               be_job_o,
   output logic [ChanW-1:0]                  be_chan_o,
   output logic                              be_valid_o,
   input  logic                              be_ready_i,
   input  logic                              be_rsp_valid_i,
   output logic                              be_rsp_ready_o,
   output logic [NumChan-1:0]                busy_o,
   output logic                              err_o
);

   logic [ChanW-1:0]                rr_q, rr_d;
   logic [NumChan-1:0]              req;
   logic                            gnt_found;
   logic [ChanW-1:0]                gnt_idx;
   logic                            accept, retire;

   logic                            out_valid_q;
   logic [JobWidth-1:0]             out_job_q;
   logic [ChanW-1:0]                out_chan_q;

   logic [ChanW-1:0]                fifo_mem [Depth];
   logic [PtrW-1:0]                 wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]                 fifo_cnt_q;
   logic                            fifo_full, fifo_empty;
   logic [ChanW-1:0]                head;

   logic [NumChan-1:0]              ret_vec;
   logic [NumChan-1:0][IdWidth-1:0] next_id_q, done_id_q;
   logic [NumChan-1:0][CntW-1:0]    out_cnt_q;
   logic                            err_q;

   // Request mask: with priority enabled, the high-priority requesters hide all
   // others as long as at least one of them is requesting.
   always_comb begin
      req = job_valid_i;
`ifdef CHESHIRE_IDMA_SCHED_PRIO_EN
      if ((job_valid_i & prio_i) != '0) req = job_valid_i & prio_i;
`endif
   end

   // Round robin: the first requester found at or after rr_q, with wrap-around.
   always_comb begin
      int unsigned cand;
      // NOTE: every combinational output gets a default before any branch, so
      // no path leaves a value unassigned and no latch is inferred.
      cand      = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned i = 0; i < NumChan; i++) begin
         cand = 32'(rr_q) + i;
         if (cand >= NumChan) cand = cand - NumChan;
         if (!gnt_found && req[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[ChanW-1:0];
         end
      end
   end

   assign fifo_full  = (fifo_cnt_q == CntW'(Depth));
   assign fifo_empty = (fifo_cnt_q == '0);
   assign head       = fifo_mem[rd_ptr_q];
   assign retire     = be_rsp_valid_i && !fifo_empty;

   // A retirement in the same cycle frees a slot, so a full FIFO still accepts
   // (pop before push).
   assign accept = gnt_found && !rst_i && (!out_valid_q || be_ready_i)
                   && (!fifo_full || retire);

   always_comb begin
      job_ready_o = '0;
      ret_vec     = '0;
      rr_d        = rr_q;
      if (accept) begin
         job_ready_o[gnt_idx] = 1'b1;
         if (32'(gnt_idx) + 1 >= NumChan) rr_d = '0;
         else                             rr_d = gnt_idx + ChanW'(1);
      end
      if (retire) ret_vec[head] = 1'b1;
   end

   // Control state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: sequential state is written with non-blocking assignments only,
         // so every flop samples the values from before the clock edge.
         rr_q        <= '0;
         out_valid_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         err_q       <= 1'b0;
         for (int c = 0; c < NumChan; c++) begin
            next_id_q[c] <= IdWidth'(1);
            done_id_q[c] <= '0;
            out_cnt_q[c] <= '0;
         end
      end else begin
         rr_q <= rr_d;
         if (accept)          out_valid_q <= 1'b1;
         else if (be_ready_i) out_valid_q <= 1'b0;
         if (accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (retire) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (accept && !retire)      fifo_cnt_q <= fifo_cnt_q + CntW'(1);
         else if (!accept && retire) fifo_cnt_q <= fifo_cnt_q - CntW'(1);
         if (be_rsp_valid_i && fifo_empty) err_q <= 1'b1;
         for (int c = 0; c < NumChan; c++) begin
            if (job_ready_o[c]) next_id_q[c] <= next_id_q[c] + IdWidth'(1);
            if (ret_vec[c])     done_id_q[c] <= done_id_q[c] + IdWidth'(1);
            if (job_ready_o[c] && !ret_vec[c])      out_cnt_q[c] <= out_cnt_q[c] + CntW'(1);
            else if (!job_ready_o[c] && ret_vec[c]) out_cnt_q[c] <= out_cnt_q[c] - CntW'(1);
         end
      end
   end

   // Datapath storage.
   // NOTE: payload registers and FIFO storage are not reset. Only the valid
   // flag and the pointers are reset, and those decide whether the contents
   // are ever used.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         out_job_q          <= job_i[gnt_idx];
         out_chan_q         <= gnt_idx;
         fifo_mem[wr_ptr_q] <= gnt_idx;
      end
   end

   always_comb begin
      busy_o = '0;
      for (int c = 0; c < NumChan; c++) busy_o[c] = (out_cnt_q[c] != '0);
   end

   assign next_id_o      = next_id_q;
   assign done_id_o      = done_id_q;
   assign be_job_o       = out_job_q;
   assign be_chan_o      = out_chan_q;
   assign be_valid_o     = out_valid_q;
   assign be_rsp_ready_o = 1'b1;
   assign err_o          = err_q;

endmodule

// File: tb/tb_cheshire_idma_chan_sched.sv
// -----------------------------------------------------------------------------
// tb_cheshire_idma_chan_sched
//
// Directed testbench for cheshire_idma_chan_sched with NumChan=2, IdWidth=4,
// JobWidth=16 and Depth=4. Inputs change on the falling edge. Outputs are
// checked 1 time unit after that. An optional auto-responder returns one
// completion per backend handoff. The response is asserted in the second
// cycle after the handoff.
// -----------------------------------------------------------------------------
module tb_cheshire_idma_chan_sched;

   localparam int unsigned NC = 2;
   localparam int unsigned IW = 4;
   localparam int unsigned JW = 16;
   localparam int unsigned D  = 4;

   logic                   clk;
   logic                   rst;
   logic [NC-1:0][JW-1:0]  job;
   logic [NC-1:0]          job_valid;
   logic [NC-1:0]          job_ready;
`ifdef CHESHIRE_IDMA_SCHED_PRIO_EN
   logic [NC-1:0]          prio;
`endif
   logic [NC-1:0][IW-1:0]  next_id;
   logic [NC-1:0][IW-1:0]  done_id;
   logic [JW-1:0]          be_job;
   logic [0:0]             be_chan;
   logic                   be_valid;
   logic                   be_ready;
   logic                   be_rsp_valid;
   logic                   be_rsp_ready;
   logic [NC-1:0]          busy;
   logic                   err;

   int    checks = 0;
   int    errors = 0;
   logic  auto_rsp = 1'b0;
   logic [1:0] rsp_sr = '0;

   cheshire_idma_chan_sched #(
      .NumChan (NC),
      .IdWidth (IW),
      .JobWidth(JW),
      .Depth   (D)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .job_i         (job),
      .job_valid_i   (job_valid),
      .job_ready_o   (job_ready),
`ifdef CHESHIRE_IDMA_SCHED_PRIO_EN
      .prio_i        (prio),
`endif
      .next_id_o     (next_id),
      .done_id_o     (done_id),
      .be_job_o      (be_job),
      .be_chan_o     (be_chan),
      .be_valid_o    (be_valid),
      .be_ready_i    (be_ready),
      .be_rsp_valid_i(be_rsp_valid),
      .be_rsp_ready_o(be_rsp_ready),
      .busy_o        (busy),
      .err_o         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock cycle. Call it from the check point after a falling
   // edge. It returns at the next falling edge.
   task automatic step();
      logic hs;
      hs = be_valid && be_ready && auto_rsp;
      @(posedge clk);
      #1;
      rsp_sr = {rsp_sr[0], hs};
      if (auto_rsp) be_rsp_valid = rsp_sr[1];
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      auto_rsp     = 1'b0;
      rsp_sr       = '0;
      be_rsp_valid = 1'b0;
      job_valid    = '0;
      be_ready     = 1'b0;
`ifdef CHESHIRE_IDMA_SCHED_PRIO_EN
      prio         = '0;
`endif
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [JW-1:0] exp_job;
      job = '0;
      do_reset();
      rst = 1'b1;

      // Reset values. job_ready stays low while reset is high, even with
      // requests present.
      job_valid = 2'b11;
      #1;
      check("rst_ready",   job_ready,  0);
      check("rst_next0",   next_id[0], 1);
      check("rst_next1",   next_id[1], 1);
      check("rst_done0",   done_id[0], 0);
      check("rst_done1",   done_id[1], 0);
      check("rst_bevalid", be_valid,   0);
      check("rst_busy",    busy,       0);
      check("rst_err",     err,        0);
      check("rst_rspready", be_rsp_ready, 1);
      rst = 1'b0;
      job_valid = '0;

      // Both channels request continuously. The grant alternates 0,1,0,1.
      be_ready = 1'b1;
      auto_rsp = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         job[0]    = 16'hA000 + 16'(i);
         job[1]    = 16'hB000 + 16'(i);
         job_valid = (i < 8) ? 2'b11 : 2'b00;
         #1;
         if (i < 8) check("t1_ready", job_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
         if (i >= 1) begin
            exp_job = ((i - 1) % 2 == 0) ? 16'hA000 + 16'(i - 1) : 16'hB000 + 16'(i - 1);
            check("t1_bevalid", be_valid, 1);
            check("t1_chan",    be_chan,  (i - 1) % 2);
            check("t1_job",     be_job,   exp_job);
         end
         step();
      end
      check("t1_next0", next_id[0], 5);
      check("t1_next1", next_id[1], 5);
      for (int i = 0; i < 5; i++) step();
      check("t1_done0", done_id[0], 4);
      check("t1_done1", done_id[1], 4);
      check("t1_busy",  busy,       0);
      check("t1_err",   err,        0);

      // Without responses, channel 0 gets exactly Depth accepts. One response
      // then allows a fifth accept in the same cycle.
      do_reset();
      be_ready  = 1'b1;
      job_valid = 2'b01;
      for (int i = 0; i < 6; i++) begin
         job[0] = 16'hC000 + 16'(i);
         #1;
         check("t2_ready", job_ready, (i < 4) ? 2'b01 : 2'b00);
         step();
      end
      check("t2_busy",  busy,       2'b01);
      check("t2_next0", next_id[0], 5);
      check("t2_done0", done_id[0], 0);
      be_rsp_valid = 1'b1;
      #1;
      check("t2_pop_push", job_ready, 2'b01);
      step();
      be_rsp_valid = 1'b0;
      #1;
      check("t2_done_after", done_id[0], 1);
      check("t2_next_after", next_id[0], 6);
      check("t2_full_again", job_ready,  2'b00);
      check("t2_busy_after", busy,       2'b01);
      check("t2_err",        err,        0);
      job_valid = '0;

      // Backend stalls. The output register holds and no further accept occurs.
      do_reset();
      job_valid = 2'b10;
      job[1]    = 16'hB123;
      #1;
      check("t3_first", job_ready, 2'b10);
      step();
      job[1] = 16'h5555;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t3_stall_ready", job_ready, 0);
         check("t3_stall_valid", be_valid,  1);
         check("t3_stall_job",   be_job,    16'hB123);
         check("t3_stall_chan",  be_chan,   1);
         step();
      end
      be_ready = 1'b1;
      #1;
      check("t3_resume", job_ready, 2'b10);
      step();
      job_valid = '0;
      #1;
      check("t3_newjob", be_job,     16'h5555);
      check("t3_valid",  be_valid,   1);
      check("t3_next1",  next_id[1], 3);
      check("t3_busy",   busy,       2'b10);
      step();

      // A response with nothing outstanding is ignored and sets the sticky
      // error flag.
      do_reset();
      be_rsp_valid = 1'b1;
      #1;
      step();
      be_rsp_valid = 1'b0;
      #1;
      check("t4_err",   err,        1);
      check("t4_done0", done_id[0], 0);
      check("t4_done1", done_id[1], 0);
      check("t4_busy",  busy,       0);
      step();
      step();
      check("t4_sticky", err, 1);

      // ID wrap on channel 1 (4-bit IDs), then reset mid-burst.
      do_reset();
      be_ready  = 1'b1;
      auto_rsp  = 1'b1;
      job_valid = 2'b10;
      for (int i = 0; i <= 16; i++) begin
         job[1] = 16'(i);
         #1;
         check("t5_next1", next_id[1], (1 + i) % 16);
         check("t5_ready", job_ready,  2'b10);
         step();
      end
      rst = 1'b1;
      #1;
      check("t5_rst_ready", job_ready, 0);
      auto_rsp     = 1'b0;
      rsp_sr       = '0;
      be_rsp_valid = 1'b0;
      step();
      check("t5_rst_next0", next_id[0], 1);
      check("t5_rst_next1", next_id[1], 1);
      check("t5_rst_done0", done_id[0], 0);
      check("t5_rst_done1", done_id[1], 0);
      check("t5_rst_valid", be_valid,   0);
      check("t5_rst_busy",  busy,       0);
      check("t5_rst_err",   err,        0);
      rst = 1'b0;
      job_valid = '0;

`ifdef CHESHIRE_IDMA_SCHED_PRIO_EN
      // The high-priority channel wins every cycle while it requests.
      do_reset();
      prio      = 2'b10;
      be_ready  = 1'b1;
      auto_rsp  = 1'b1;
      job_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t6_prio", job_ready, 2'b10);
         step();
      end
      job_valid = 2'b01;
      #1;
      check("t6_drop", job_ready, 2'b01);
      step();
      job_valid = '0;
      prio      = '0;
      for (int i = 0; i < 5; i++) step();
      check("t6_busy", busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
